// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC, IF/ID register, stall/redirect/halt
//
// Purpose: holds the word-index PC, addresses a zero-latency instruction memory,
// and captures the returned word into the IF/ID pipeline register.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall             hold PC and IF/ID (ignored while halted)
//   redirect          load redirect_pc (mod IMEM_DEPTH), squash IF/ID; wins over stall
//   redirect_pc[31:0] redirect target word index
//   imem_instr[31:0]  word read at imem_addr (combinational memory)
//   imem_addr[31:0]   current PC
//   if_id_instr/if_id_pc1/if_id_valid  IF/ID pipeline register contents
//   halted            fetch stopped on HALT_WORD
//   fetch_count[31:0] instructions issued into IF/ID (wraps)

module fetch_stage #(
    parameter int          IMEM_DEPTH = 512,
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_WORD   = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_instr,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc1,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] redirect_wrapped;

    // Sequential successor wraps at the end of instruction memory.
    assign pc_next          = (pc + 32'd1 == 32'(IMEM_DEPTH)) ? 32'd0 : pc + 32'd1;
    // Targets beyond the memory alias back into it.
    assign redirect_wrapped = redirect_pc % 32'(IMEM_DEPTH);
    assign imem_addr        = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_id_instr <= NOP_WORD;
            if_id_pc1   <= 32'd0;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        // Squash whatever was fetched at the old PC.
                        pc          <= redirect_wrapped;
                        if_id_instr <= NOP_WORD;
                        if_id_valid <= 1'b0;
                    end else if (stall) begin
                        // Everything holds.
                    end else if (imem_instr == HALT_WORD) begin
                        // PC stays on the halt word; it is never issued.
                        if_id_instr <= NOP_WORD;
                        if_id_valid <= 1'b0;
                        halted      <= 1'b1;
                        state       <= HALTED;
                    end else begin
                        if_id_instr <= imem_instr;
                        if_id_pc1   <= pc_next;
                        if_id_valid <= 1'b1;
                        fetch_count <= fetch_count + 32'd1;
                        pc          <= pc_next;
                    end
                end
                HALTED: begin
                    if_id_instr <= NOP_WORD;
                    if_id_valid <= 1'b0;
                    if (redirect) begin
                        pc     <= redirect_wrapped;
                        halted <= 1'b0;
                        state  <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table-driven testbench for fetch_stage

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc1;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [512];

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'd0;

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < 32'd512) ? mem[imem_addr[8:0]] : 32'hDEAD_BEEF;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_instr  (imem_instr),
        .imem_addr   (imem_addr),
        .if_id_instr (if_id_instr),
        .if_id_pc1   (if_id_pc1),
        .if_id_valid (if_id_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc1;
        logic        valid;
        logic        halt;
        logic [31:0] count;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                                input logic [31:0] addr, input logic [31:0] instr,
                                input logic [31:0] pc1, input logic valid,
                                input logic halt, input logic [31:0] count);
        vec_t v;
        v.stall = s; v.redirect = r; v.rpc = rpc;
        v.addr = addr; v.instr = instr; v.pc1 = pc1;
        v.valid = valid; v.halt = halt; v.count = count;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_state(input string tag, input vec_t v);
        check({tag, ".imem_addr"},   imem_addr,   v.addr);
        check({tag, ".if_id_instr"}, if_id_instr, v.instr);
        check({tag, ".if_id_pc1"},   if_id_pc1,   v.pc1);
        check({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, v.valid});
        check({tag, ".halted"},      {31'd0, halted},      {31'd0, v.halt});
        check({tag, ".fetch_count"}, fetch_count, v.count);
    endtask

    // Apply inputs for one rising edge, then compare just after it.
    task automatic run_vec(input string tag, input vec_t v);
        stall       = v.stall;
        redirect    = v.redirect;
        redirect_pc = v.rpc;
        @(posedge clk);
        #1;
        check_state(tag, v);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'(i + 10);

        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", mk(0, 0, 0, 0, NOP, 0, 0, 0, 0));
        reset = 1'b0;

        //               st rd rpc            addr instr pc1 v  h  cnt
        tbl[0]  = mk(0, 0, 0,             1,   10,  1,   1, 0, 1);
        tbl[1]  = mk(0, 0, 0,             2,   11,  2,   1, 0, 2);
        tbl[2]  = mk(1, 0, 0,             2,   11,  2,   1, 0, 2);
        tbl[3]  = mk(1, 0, 0,             2,   11,  2,   1, 0, 2);
        tbl[4]  = mk(1, 0, 0,             2,   11,  2,   1, 0, 2);
        tbl[5]  = mk(0, 0, 0,             3,   12,  3,   1, 0, 3);
        tbl[6]  = mk(0, 0, 0,             4,   13,  4,   1, 0, 4);
        tbl[7]  = mk(0, 0, 0,             5,   14,  5,   1, 0, 5);
        tbl[8]  = mk(0, 1, 100,           100, NOP, 5,   0, 0, 5);
        tbl[9]  = mk(0, 0, 0,             101, 110, 101, 1, 0, 6);
        tbl[10] = mk(1, 1, 32'hFFFF_FE07, 7,   NOP, 101, 0, 0, 6);
        tbl[11] = mk(1, 0, 0,             7,   NOP, 101, 0, 0, 6);
        tbl[12] = mk(0, 0, 0,             8,   17,  8,   1, 0, 7);

        for (int i = 0; i < 13; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // PC wrap at the top of memory.
        run_vec("wrap_redir", mk(0, 1, 510, 510, NOP, 8,   0, 0, 7));
        run_vec("wrap_510",   mk(0, 0, 0,   511, 520, 511, 1, 0, 8));
        run_vec("wrap_511",   mk(0, 0, 0,   0,   521, 0,   1, 0, 9));

        // Halt on mem[3], stall ignored while halted, redirect restarts.
        mem[3] = HALT;
        run_vec("halt_redir", mk(0, 1, 0, 0, NOP, 0, 0, 0, 9));
        run_vec("halt_f0",    mk(0, 0, 0, 1, 10,  1, 1, 0, 10));
        run_vec("halt_f1",    mk(0, 0, 0, 2, 11,  2, 1, 0, 11));
        run_vec("halt_f2",    mk(0, 0, 0, 3, 12,  3, 1, 0, 12));
        run_vec("halt_hit",   mk(0, 0, 0, 3, NOP, 3, 0, 1, 12));
        run_vec("halt_stall", mk(1, 0, 0, 3, NOP, 3, 0, 1, 12));
        run_vec("halt_hold",  mk(0, 0, 0, 3, NOP, 3, 0, 1, 12));
        run_vec("halt_exit",  mk(1, 1, 0, 0, NOP, 3, 0, 0, 12));
        run_vec("halt_rf0",   mk(0, 0, 0, 1, 10,  1, 1, 0, 13));
        run_vec("halt_rf1",   mk(0, 0, 0, 2, 11,  2, 1, 0, 14));
        run_vec("halt_rf2",   mk(0, 0, 0, 3, 12,  3, 1, 0, 15));
        // Redirect coinciding with the halt word: no halt.
        run_vec("halt_squash", mk(0, 1, 50, 50, NOP, 3,  0, 0, 15));
        run_vec("halt_after",  mk(0, 0, 0,  51, 60,  51, 1, 0, 16));

        // Reset mid-run beats stall and redirect.
        reset = 1'b1;
        run_vec("reset_mid", mk(1, 1, 77, 0, NOP, 0, 0, 0, 0));
        reset = 1'b0;
        run_vec("reset_run", mk(0, 0, 0, 1, 10, 1, 1, 0, 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
